cassette_transport: RTL and testbench
=====================================

# cassette_transport

Parametrised tape-transport model: a mode state machine (STOP/PLAY/FF/REW) drives a programmable-rate position counter. It produces the `pos`/`max` pair the cassette overlay consumes, plus motor and end-of-tape status. It sits in `soc` between the command source (OSD/keyboard/CPU) and the overlay. It replaces the free-running divider-and-wrap counter with a controllable, loop-optional transport.

## Interface
- `POS_W`, 24: width of tape position and length.
- `DIV_W`, 13: width of the step-rate divider.
- `FF_STEP`, 8: positions moved per step in FF and REW.
- `clk_sys`  in  1: single clock; all logic on the rising edge.
- `reset_n`  in  1: reset; synchronous, active-low.
- `cmd_valid`  in  1: command strobe.
- `cmd`  in  2: 0=STOP, 1=PLAY, 2=FF, 3=REW.
- `cmd_ready`  out  1: high whenever `reset_n`=1; the command is accepted on a cycle with `cmd_valid & cmd_ready`.
- `rate`  in  DIV_W: step period minus one, in clocks. Sampled every cycle.
- `tape_len`  in  POS_W: last valid position. Sampled every cycle.
- `loop_en`  in  1: at end of tape in PLAY/FF, wrap to 0 instead of stopping.
- `pos`  out  POS_W: current tape position, 0..`max`.
- `max`  out  POS_W: registered copy of `tape_len`.
- `mode`  out  2: current state, same encoding as `cmd`.
- `motor`  out  1: high in PLAY, FF and REW.
- `step`  out  1: one-cycle pulse on every cycle `pos` is updated by motion.
- `eot`  out  1: one-cycle pulse when end of tape is reached.
- `bot`  out  1: one-cycle pulse when REW reaches 0.

## Operation
- States: STOP, PLAY, FF, REW. An accepted `cmd` loads the state unconditionally, including re-issuing the current mode. Every accepted command clears the divider.
- Divider:
  - In STOP the divider is held at 0.
  - Otherwise `div` counts 0..`rate`. When `div`=`rate`, `div`←0 and a motion step occurs.
  - `rate`=0 gives a step every cycle.
- Motion step:
  - PLAY: `pos`+1.
  - FF: `pos`+FF_STEP.
  - REW: `pos`−FF_STEP.
  - Arithmetic is POS_W+1 bits wide, so there is no silent wrap.
- End of tape (PLAY/FF, computed sum > `max`, or sum = `max` in PLAY):
  - `loop_en`=1: `pos`←0 if the sum > `max`, else `pos`←`max`. Mode is unchanged. `eot` pulses when `pos` becomes `max` or wraps.
  - `loop_en`=0: `pos`←`max`, mode←STOP, `eot` pulses.
- Start of tape (REW, `pos` < FF_STEP or `pos`−FF_STEP = 0): `pos`←0, mode←STOP, `bot` pulses.
- Length change: if `tape_len` < `pos`, then `pos`←`tape_len` on the next cycle. Mode is unchanged; no `eot`.
- `tape_len`=0: `pos` is held at 0. Any PLAY/FF/REW command is accepted and the state goes to STOP on the following cycle. No pulses.
- Command and step on the same cycle: the command wins. The step is discarded, and the divider and mode are loaded from the command.

## Timing
- Reset (`reset_n`=0 at an edge): `pos`=0, `max`=0, `mode`=STOP, `div`=0, `motor`=0, `step`=`eot`=`bot`=0, `cmd_ready`=0. Reset mid-motion aborts immediately.
- Command accepted at edge N: `mode`/`motor` change at N+1, and `div`=0 at N+1.
- First step: `pos` updates at edge N+1+`rate`+1. Subsequent steps follow every `rate`+1 cycles.
- `step`, `eot` and `bot` are registered. Each is high for exactly the one cycle in which the new `pos` is first visible.
- `mode`←STOP from end or start of tape is visible in the same cycle as `eot`/`bot`.
- `max` lags `tape_len` by 1 cycle. The length clamp lands 1 cycle after `max` updates.
- A `rate` change mid-count takes effect at the next compare. If `div` > new `rate`, the divider runs on until it wraps at 2^DIV_W.

## Test plan
- Reset, then PLAY with `rate`=3, `tape_len`=10, `loop_en`=0 -> `motor`=1 at N+1; `pos`=1 at N+5, 2 at N+9, …; `pos`=10 with `eot` and `mode`=STOP at N+41.
- Same as above with `loop_en`=1 -> `pos` reaches 10 with `eot` pulse, next step `pos`=0; mode stays PLAY; 11 steps per loop.
- FF_STEP=8, `tape_len`=20, `rate`=0, FF from 0 -> `pos` 8, 16, then 20 with `eot`, STOP. REW from 20 -> 12, 4, then 0 with `bot`, STOP.
- While PLAYing at `pos`=7, drive `tape_len`=5 -> `max`=5 next cycle, `pos`=5 the cycle after; no `eot`; mode stays PLAY.
- Issue a STOP command on the exact cycle `div`=`rate` -> `pos` is unchanged, no `step`, `mode`=STOP next cycle. Also assert `reset_n`=0 mid-FF -> all outputs at reset values on the next cycle.
- `tape_len`=0, PLAY -> `mode`=STOP one cycle after acceptance; `pos`=0; no `eot`/`step`.

Source files
------------

// File: rtl/cassette_transport.sv
// Tape transport: STOP/PLAY/FF/REW mode FSM with a programmable step divider driving pos/max for the overlay.
// Latency: a command lands at the capturing edge; the first step comes rate+1 edges later. Always ready out of reset.
module cassette_transport #(
  parameter int POS_W   = 24,
  parameter int DIV_W   = 13,
  parameter int FF_STEP = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] rate,
  input  logic [POS_W-1:0] tape_len,
  input  logic             loop_en,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] max,
  output logic [1:0]       mode,
  output logic             motor,
  output logic             step,
  output logic             eot,
  output logic             bot
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_PLAY = 2'd1,
    ST_FF   = 2'd2,
    ST_REW  = 2'd3
  } mode_t;

  localparam logic [POS_W:0]   FWD_PLAY = (POS_W+1)'(1);
  localparam logic [POS_W:0]   FWD_FF   = (POS_W+1)'(FF_STEP);
  localparam logic [POS_W-1:0] REW_STEP = POS_W'(FF_STEP);

  mode_t            mode_q, mode_nx;
  logic [DIV_W-1:0] div_q, div_nx;
  logic [POS_W-1:0] pos_nx;
  logic             step_nx, eot_nx, bot_nx;

  logic [POS_W:0]   pos_ext, max_ext, fwd_sum;
  logic             at_end, clamp, cmd_acc;

  assign cmd_ready = reset_n;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign mode      = mode_q;
  assign motor     = (mode_q != ST_STOP);

  // One extra bit so an overshoot past max is visible instead of wrapping.
  assign pos_ext = {1'b0, pos};
  assign max_ext = {1'b0, max};
  assign fwd_sum = pos_ext + ((mode_q == ST_PLAY) ? FWD_PLAY : FWD_FF);
  assign at_end  = (fwd_sum > max_ext) || ((mode_q == ST_PLAY) && (fwd_sum == max_ext));
  assign clamp   = (max < pos);

  always_comb begin
    mode_nx = mode_q;
    div_nx  = div_q;
    pos_nx  = pos;
    step_nx = 1'b0;
    eot_nx  = 1'b0;
    bot_nx  = 1'b0;

    if (cmd_acc) begin
      // A command always wins over a coincident step; an empty tape refuses motion.
      div_nx  = '0;
      mode_nx = (max == '0) ? ST_STOP : mode_t'(cmd);
    end else if (mode_q == ST_STOP) begin
      div_nx = '0;
    end else if (max == '0) begin
      mode_nx = ST_STOP;
      div_nx  = '0;
    end else if (div_q != rate) begin
      div_nx = div_q + DIV_W'(1);
    end else begin
      div_nx = '0;
      if (!clamp) begin
        step_nx = 1'b1;
        case (mode_q)
          ST_PLAY, ST_FF: begin
            if (at_end) begin
              eot_nx = 1'b1;
              if (loop_en) begin
                pos_nx = (fwd_sum > max_ext) ? '0 : max;
              end else begin
                pos_nx  = max;
                mode_nx = ST_STOP;
              end
            end else begin
              pos_nx = fwd_sum[POS_W-1:0];
            end
          end
          ST_REW: begin
            if (pos <= REW_STEP) begin
              pos_nx  = '0;
              mode_nx = ST_STOP;
              bot_nx  = 1'b1;
            end else begin
              pos_nx = pos - REW_STEP;
            end
          end
          default: ;
        endcase
      end
    end

    // A shortened tape pulls pos back silently, whatever else happened this cycle.
    if (clamp) begin
      pos_nx = max;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mode_q <= ST_STOP;
      div_q  <= '0;
      pos    <= '0;
      max    <= '0;
      step   <= 1'b0;
      eot    <= 1'b0;
      bot    <= 1'b0;
    end else begin
      mode_q <= mode_nx;
      div_q  <= div_nx;
      pos    <= pos_nx;
      max    <= tape_len;
      step   <= step_nx;
      eot    <= eot_nx;
      bot    <= bot_nx;
    end
  end

endmodule

// File: tb/tb_cassette_transport.sv
// Directed bench for cassette_transport: each scenario task drives the DUT and checks against hand-computed values.
module tb_cassette_transport;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [12:0] rate;
  logic [23:0] tape_len;
  logic        loop_en;
  logic [23:0] pos;
  logic [23:0] max;
  logic [1:0]  mode;
  logic        motor;
  logic        step;
  logic        eot;
  logic        bot;

  int tests = 0;
  int fails = 0;

  cassette_transport #(.POS_W(24), .DIV_W(13), .FF_STEP(8)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .rate      (rate),
    .tape_len  (tape_len),
    .loop_en   (loop_en),
    .pos       (pos),
    .max       (max),
    .mode      (mode),
    .motor     (motor),
    .step      (step),
    .eot       (eot),
    .bot       (bot)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    tick();
  endtask

  // Presents a command for exactly one edge; values seen afterwards are from the capturing edge.
  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
    rate = 13'd3; tape_len = 24'd10; loop_en = 1'b0;
    ticks(2);
    tests++; if (pos !== 24'd0) begin fails++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    tests++; if (max !== 24'd0) begin fails++; $display("FAIL reset_max: got %0d expected 0", max); end
    tests++; if (mode !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    tests++; if (motor !== 1'b0) begin fails++; $display("FAIL reset_motor: got %b expected 0", motor); end
    tests++; if ({step, eot, bot} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {step, eot, bot}); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    reset_n = 1'b1;
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b expected 1", cmd_ready); end
    tests++; if (max !== 24'd10) begin fails++; $display("FAIL max_follow: got %0d expected 10", max); end
  endtask

  task automatic test_play_noloop();
    issue(2'd1);
    tests++; if (mode !== 2'd1 || motor !== 1'b1) begin fails++; $display("FAIL play_start: got mode %0d motor %b expected 1 1", mode, motor); end
    tests++; if (pos !== 24'd0) begin fails++; $display("FAIL play_start_pos: got %0d expected 0", pos); end
    for (int k = 1; k <= 10; k++) begin
      ticks(3);
      tests++; if (pos !== 24'(k - 1) || step !== 1'b0) begin fails++; $display("FAIL play_hold_%0d: got pos %0d step %b expected %0d 0", k, pos, step, k - 1); end
      tick();
      tests++; if (pos !== 24'(k) || step !== 1'b1) begin fails++; $display("FAIL play_step_%0d: got pos %0d step %b expected %0d 1", k, pos, step, k); end
      tests++; if (eot !== (k == 10)) begin fails++; $display("FAIL play_eot_%0d: got %b expected %b", k, eot, k == 10); end
      tests++; if (mode !== ((k == 10) ? 2'd0 : 2'd1)) begin fails++; $display("FAIL play_mode_%0d: got %0d", k, mode); end
    end
    tick();
    tests++; if (pos !== 24'd10 || eot !== 1'b0 || step !== 1'b0 || motor !== 1'b0) begin fails++; $display("FAIL play_after_eot: got pos %0d eot %b step %b motor %b expected 10 0 0 0", pos, eot, step, motor); end
  endtask

  task automatic test_play_loop();
    logic [23:0] exp_pos;
    loop_en = 1'b1;
    do_reset();
    issue(2'd1);
    for (int k = 1; k <= 12; k++) begin
      exp_pos = 24'(k % 11);
      ticks(4);
      tests++; if (pos !== exp_pos) begin fails++; $display("FAIL loop_pos_%0d: got %0d expected %0d", k, pos, exp_pos); end
      tests++; if (eot !== (k == 10 || k == 11)) begin fails++; $display("FAIL loop_eot_%0d: got %b expected %b", k, eot, k == 10 || k == 11); end
      tests++; if (mode !== 2'd1) begin fails++; $display("FAIL loop_mode_%0d: got %0d expected 1", k, mode); end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_ff_rew();
    logic [23:0] ff_exp [3];
    logic [23:0] rw_exp [3];
    ff_exp = '{24'd8, 24'd16, 24'd20};
    rw_exp = '{24'd12, 24'd4, 24'd0};
    tape_len = 24'd20; rate = 13'd0;
    do_reset();
    issue(2'd2);
    tests++; if (mode !== 2'd2) begin fails++; $display("FAIL ff_mode: got %0d expected 2", mode); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (pos !== ff_exp[k] || step !== 1'b1) begin fails++; $display("FAIL ff_pos_%0d: got %0d step %b expected %0d 1", k, pos, step, ff_exp[k]); end
      tests++; if (eot !== (k == 2) || mode !== ((k == 2) ? 2'd0 : 2'd2)) begin fails++; $display("FAIL ff_end_%0d: got eot %b mode %0d", k, eot, mode); end
    end
    issue(2'd3);
    tests++; if (mode !== 2'd3 || pos !== 24'd20) begin fails++; $display("FAIL rew_start: got mode %0d pos %0d expected 3 20", mode, pos); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (pos !== rw_exp[k]) begin fails++; $display("FAIL rew_pos_%0d: got %0d expected %0d", k, pos, rw_exp[k]); end
      tests++; if (bot !== (k == 2) || eot !== 1'b0 || mode !== ((k == 2) ? 2'd0 : 2'd3)) begin fails++; $display("FAIL rew_end_%0d: got bot %b eot %b mode %0d", k, bot, eot, mode); end
    end
    tick();
    tests++; if (bot !== 1'b0 || pos !== 24'd0) begin fails++; $display("FAIL rew_after_bot: got bot %b pos %0d expected 0 0", bot, pos); end
  endtask

  task automatic test_len_change();
    tape_len = 24'd10; rate = 13'd3;
    do_reset();
    issue(2'd1);
    ticks(28);
    tests++; if (pos !== 24'd7) begin fails++; $display("FAIL len_pre_pos: got %0d expected 7", pos); end
    tape_len = 24'd5;
    tick();
    tests++; if (max !== 24'd5 || pos !== 24'd7) begin fails++; $display("FAIL len_max: got max %0d pos %0d expected 5 7", max, pos); end
    tick();
    tests++; if (pos !== 24'd5 || mode !== 2'd1 || eot !== 1'b0) begin fails++; $display("FAIL len_clamp: got pos %0d mode %0d eot %b expected 5 1 0", pos, mode, eot); end
  endtask

  task automatic test_cmd_step_collision();
    tape_len = 24'd10; rate = 13'd3;
    do_reset();
    issue(2'd1);
    ticks(4);
    tests++; if (pos !== 24'd1) begin fails++; $display("FAIL coll_pre: got %0d expected 1", pos); end
    ticks(3);
    issue(2'd0);
    tests++; if (pos !== 24'd1 || step !== 1'b0) begin fails++; $display("FAIL coll_step: got pos %0d step %b expected 1 0", pos, step); end
    tests++; if (mode !== 2'd0 || motor !== 1'b0) begin fails++; $display("FAIL coll_mode: got mode %0d motor %b expected 0 0", mode, motor); end
    ticks(6);
    tests++; if (pos !== 24'd1) begin fails++; $display("FAIL coll_stopped: got %0d expected 1", pos); end
  endtask

  task automatic test_reset_mid_ff();
    tape_len = 24'd100; rate = 13'd0;
    do_reset();
    issue(2'd2);
    ticks(3);
    tests++; if (pos !== 24'd24) begin fails++; $display("FAIL midff_pos: got %0d expected 24", pos); end
    reset_n = 1'b0;
    tick();
    tests++; if (pos !== 24'd0 || max !== 24'd0 || mode !== 2'd0 || motor !== 1'b0) begin fails++; $display("FAIL midff_reset: got pos %0d max %0d mode %0d motor %b", pos, max, mode, motor); end
    tests++; if ({step, eot, bot, cmd_ready} !== 4'b0000) begin fails++; $display("FAIL midff_reset_flags: got %b expected 0000", {step, eot, bot, cmd_ready}); end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_len();
    tape_len = 24'd0; rate = 13'd0;
    do_reset();
    issue(2'd1);
    tests++; if (mode !== 2'd0 || motor !== 1'b0 || pos !== 24'd0) begin fails++; $display("FAIL zero_play: got mode %0d motor %b pos %0d expected 0 0 0", mode, motor, pos); end
    issue(2'd2);
    ticks(3);
    tests++; if (mode !== 2'd0 || pos !== 24'd0 || {step, eot, bot} !== 3'b000) begin fails++; $display("FAIL zero_ff: got mode %0d pos %0d pulses %b", mode, pos, {step, eot, bot}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_play_noloop();
    test_play_loop();
    test_ff_rew();
    test_len_change();
    test_cmd_step_collision();
    test_reset_mid_ff();
    test_zero_len();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
